// File: rtl/pio_hex_display_pkg.sv
// Shared types and constants for the PIO hex display.
// Segment encodings are active-low, bit0=a .. bit6=g.
package pio_hex_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_FLASH_OFF,
    S_FLASH_ON
  } state_e;

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_ZERO  = 7'h40;

  // Entry n holds the glyph for hex digit n.
  localparam logic [15:0][6:0] SEG_TABLE = {
    7'h0E, 7'h06, 7'h21, 7'h46,
    7'h03, 7'h08, 7'h10, 7'h00,
    7'h78, 7'h02, 7'h12, 7'h19,
    7'h30, 7'h24, 7'h79, 7'h40
  };

endpackage

// File: rtl/pio_hex_display_hex7seg.sv
// One hex digit to active-low seven-segment glyph.
// Purely combinational.
module hex7seg
  import pio_hex_pkg::*;
(
  input  logic [3:0] dig_i,
  output logic [6:0] seg_o
);

  assign seg_o = SEG_TABLE[dig_i];

endmodule

// File: rtl/pio_hex_display.sv
// Shows the LED PIO value on hex1:hex0 with a flash on change,
// and a saturating change counter on hex5:hex2.
module pio_hex_display
  import pio_hex_pkg::*;
#(
  parameter int unsigned FLASH_CYC   = 12_500_000,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [7:0] pio_value,
  input  logic       freeze,
  input  logic       clear_n,
  output logic [6:0] hex0,
  output logic [6:0] hex1,
  output logic [6:0] hex2,
  output logic [6:0] hex3,
  output logic [6:0] hex4,
  output logic [6:0] hex5,
  output logic       change_pulse
);

  localparam logic [23:0] RELOAD = 24'(FLASH_CYC - 1);

  logic [7:0]             last_q;
  logic [7:0]             disp_q, disp_d;
  logic [15:0]            cnt_q, cnt_d;
  logic [23:0]            tmr_q, tmr_d;
  state_e                 st_q, st_d;
  logic                   cp_q;
  logic [SYNC_STAGES-1:0] frz_q;
  logic [SYNC_STAGES-1:0] clr_q;
  logic                   clr_prev_q;
  logic [6:0]             hex_q [6];
  logic [3:0]             nib [6];
  logic [6:0]             seg [6];

  logic freeze_s;
  logic clr_s;
  logic clr_fall;
  logic change;
  logic accept;

  assign freeze_s = frz_q[SYNC_STAGES-1];
  assign clr_s    = clr_q[SYNC_STAGES-1];
  assign clr_fall = clr_prev_q & ~clr_s;
  assign change   = (pio_value != last_q);
  assign accept   = change & ~freeze_s;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      frz_q      <= '0;
      clr_q      <= '1;
      clr_prev_q <= 1'b1;
    end else begin
      frz_q      <= {frz_q[SYNC_STAGES-2:0], freeze};
      clr_q      <= {clr_q[SYNC_STAGES-2:0], clear_n};
      clr_prev_q <= clr_s;
    end
  end

  assign disp_d = accept ? pio_value : disp_q;

  // A clear coinciding with a change counts that change.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_fall) begin
      cnt_d = change ? 16'd1 : 16'd0;
    end else if (change && (cnt_q != 16'hFFFF)) begin
      cnt_d = cnt_q + 16'd1;
    end
  end

  always_comb begin
    st_d  = st_q;
    tmr_d = tmr_q;
    unique case (st_q)
      S_IDLE: begin
        if (accept) begin
          st_d  = S_FLASH_OFF;
          tmr_d = RELOAD;
        end
      end
      S_FLASH_OFF: begin
        if (accept) begin
          tmr_d = RELOAD;
        end else if (tmr_q == 24'd0) begin
          st_d  = S_FLASH_ON;
          tmr_d = RELOAD;
        end else begin
          tmr_d = tmr_q - 24'd1;
        end
      end
      S_FLASH_ON: begin
        if (accept) begin
          st_d  = S_FLASH_OFF;
          tmr_d = RELOAD;
        end else if (tmr_q == 24'd0) begin
          st_d  = S_IDLE;
        end else begin
          tmr_d = tmr_q - 24'd1;
        end
      end
      default: begin
        st_d  = S_IDLE;
        tmr_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      last_q <= '0;
      disp_q <= '0;
      cnt_q  <= '0;
      tmr_q  <= '0;
      st_q   <= S_IDLE;
      cp_q   <= 1'b0;
    end else begin
      last_q <= pio_value;
      disp_q <= disp_d;
      cnt_q  <= cnt_d;
      tmr_q  <= tmr_d;
      st_q   <= st_d;
      cp_q   <= change;
    end
  end

  // Value digits follow the next state so blanking lands with the change;
  // counter digits trail the counter register by one clock.
  always_comb begin
    nib[0] = disp_d[3:0];
    nib[1] = disp_d[7:4];
    nib[2] = cnt_q[3:0];
    nib[3] = cnt_q[7:4];
    nib[4] = cnt_q[11:8];
    nib[5] = cnt_q[15:12];
  end

  for (genvar i = 0; i < 6; i++) begin : g_seg
    hex7seg u_seg (
      .dig_i (nib[i]),
      .seg_o (seg[i])
    );
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < 6; i++) begin
        hex_q[i] <= SEG_ZERO;
      end
    end else begin
      for (int i = 0; i < 6; i++) begin
        if (i < 2 && st_d == S_FLASH_OFF) begin
          hex_q[i] <= SEG_BLANK;
        end else begin
          hex_q[i] <= seg[i];
        end
      end
    end
  end

  assign hex0         = hex_q[0];
  assign hex1         = hex_q[1];
  assign hex2         = hex_q[2];
  assign hex3         = hex_q[3];
  assign hex4         = hex_q[4];
  assign hex5         = hex_q[5];
  assign change_pulse = cp_q;

endmodule

// File: tb/tb_pio_hex_display.sv
// Directed scoreboard bench for pio_hex_display with FLASH_CYC=4.
module tb_pio_hex_display;

  logic       clk;
  logic       reset_n;
  logic [7:0] pio_value;
  logic       freeze;
  logic       clear_n;
  logic [6:0] hex0, hex1, hex2, hex3, hex4, hex5;
  logic       change_pulse;

  int checks = 0;
  int errors = 0;

  logic [42:0] exp_q [$];
  string       tag_q [$];

  pio_hex_display #(
    .FLASH_CYC   (4),
    .SYNC_STAGES (2)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .pio_value    (pio_value),
    .freeze       (freeze),
    .clear_n      (clear_n),
    .hex0         (hex0),
    .hex1         (hex1),
    .hex2         (hex2),
    .hex3         (hex3),
    .hex4         (hex4),
    .hex5         (hex5),
    .change_pulse (change_pulse)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [6:0] seg(input logic [3:0] d);
    case (d)
      4'h0: seg = 7'h40;
      4'h1: seg = 7'h79;
      4'h2: seg = 7'h24;
      4'h3: seg = 7'h30;
      4'h4: seg = 7'h19;
      4'h5: seg = 7'h12;
      4'h6: seg = 7'h02;
      4'h7: seg = 7'h78;
      4'h8: seg = 7'h00;
      4'h9: seg = 7'h10;
      4'hA: seg = 7'h08;
      4'hB: seg = 7'h03;
      4'hC: seg = 7'h46;
      4'hD: seg = 7'h21;
      4'hE: seg = 7'h06;
      default: seg = 7'h0E;
    endcase
  endfunction

  function automatic logic [42:0] mk(input logic [7:0] dv,
                                     input logic blank,
                                     input logic [15:0] cnt,
                                     input logic cp);
    logic [6:0] h1, h0;
    h1 = blank ? 7'h7F : seg(dv[7:4]);
    h0 = blank ? 7'h7F : seg(dv[3:0]);
    mk = {cp, seg(cnt[15:12]), seg(cnt[11:8]),
          seg(cnt[7:4]), seg(cnt[3:0]), h1, h0};
  endfunction

  task automatic compare_front();
    logic [42:0] e;
    logic [42:0] o;
    string       t;
    e = exp_q.pop_front();
    t = tag_q.pop_front();
    o = {change_pulse, hex5, hex4, hex3, hex2, hex1, hex0};
    checks++;
    assert (o === e) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", t, o, e);
    end
  endtask

  task automatic expect_now(input string t, input logic [42:0] e);
    exp_q.push_back(e);
    tag_q.push_back(t);
    compare_front();
  endtask

  task automatic step(input string t, input logic [42:0] e);
    exp_q.push_back(e);
    tag_q.push_back(t);
    @(posedge clk);
    @(negedge clk);
    compare_front();
  endtask

  initial begin
    reset_n   = 1'b0;
    pio_value = 8'h00;
    freeze    = 1'b0;
    clear_n   = 1'b1;
    @(negedge clk);
    expect_now("reset", mk(8'h00, 1'b0, 16'h0000, 1'b0));
    reset_n = 1'b1;

    for (int i = 0; i < 3; i++) step("idle0", mk(8'h00, 0, 16'h0, 0));

    pio_value = 8'hA5;
    step("a5_pulse", mk(8'hA5, 1, 16'h0, 1));
    for (int i = 0; i < 3; i++) step("a5_blank", mk(8'hA5, 1, 16'h1, 0));
    step("a5_on0", mk(8'hA5, 0, 16'h1, 0));
    step("a5_on1", mk(8'hA5, 0, 16'h1, 0));

    pio_value = 8'h3C;
    step("3c_pulse", mk(8'h3C, 1, 16'h1, 1));
    for (int i = 0; i < 3; i++) step("3c_blank", mk(8'h3C, 1, 16'h2, 0));
    for (int i = 0; i < 6; i++) step("3c_show", mk(8'h3C, 0, 16'h2, 0));

    freeze = 1'b1;
    for (int i = 0; i < 3; i++) step("frz_sync", mk(8'h3C, 0, 16'h2, 0));
    pio_value = 8'h11;
    step("frz_pulse", mk(8'h3C, 0, 16'h2, 1));
    step("frz_cnt3", mk(8'h3C, 0, 16'h3, 0));
    step("frz_idle", mk(8'h3C, 0, 16'h3, 0));

    for (int i = 0; i < 65531; i++) begin
      pio_value = (i % 2 == 0) ? 8'h22 : 8'h11;
      @(posedge clk);
      @(negedge clk);
    end
    step("cnt_fffe", mk(8'h3C, 0, 16'hFFFE, 0));
    pio_value = 8'h11;
    step("sat_1", mk(8'h3C, 0, 16'hFFFE, 1));
    pio_value = 8'h22;
    step("sat_2", mk(8'h3C, 0, 16'hFFFF, 1));
    pio_value = 8'h11;
    step("sat_3", mk(8'h3C, 0, 16'hFFFF, 1));
    step("sat_hold", mk(8'h3C, 0, 16'hFFFF, 0));

    clear_n = 1'b0;
    step("clr_sync0", mk(8'h3C, 0, 16'hFFFF, 0));
    step("clr_sync1", mk(8'h3C, 0, 16'hFFFF, 0));
    pio_value = 8'h22;
    step("clr_chg", mk(8'h3C, 0, 16'hFFFF, 1));
    step("clr_cnt1", mk(8'h3C, 0, 16'h1, 0));
    clear_n = 1'b1;
    for (int i = 0; i < 3; i++) step("clr_rel", mk(8'h3C, 0, 16'h1, 0));

    freeze = 1'b0;
    step("unfrz0", mk(8'h3C, 0, 16'h1, 0));
    step("unfrz1", mk(8'h3C, 0, 16'h1, 0));
    pio_value = 8'h5A;
    step("5a_pulse", mk(8'h5A, 1, 16'h1, 1));
    step("5a_blank", mk(8'h5A, 1, 16'h2, 0));

    #2;
    reset_n = 1'b0;
    #1;
    expect_now("async_rst", mk(8'h00, 0, 16'h0, 0));
    @(negedge clk);
    expect_now("rst_held", mk(8'h00, 0, 16'h0, 0));
    reset_n = 1'b1;
    step("post_rst_chg", mk(8'h5A, 1, 16'h0, 1));
    step("post_rst_cnt", mk(8'h5A, 1, 16'h1, 0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pio_hex_display.md
PIO_HEX_DISPLAY -- requirements
Module: pio_hex_display

Interface
REQ-001 SHALL have parameter FLASH_CYC, default 12_500_000: length in clocks of each flash phase (250 ms at 50 MHz); legal range 1..2^24-1.
REQ-002 SHALL have parameter SYNC_STAGES, default 2: synchroniser depth for freeze and clear_n; legal range 2..4.
REQ-003 SHALL have port clk, input, 1: single clock (CLOCK_50); all logic is in this domain.
REQ-004 SHALL have port reset_n, input, 1: reset, asynchronous assert, active-low.
REQ-005 SHALL have port pio_value, input, 8: LED PIO export from the HPS system, synchronous to clk.
REQ-006 SHALL have port freeze, input, 1: slide switch, asynchronous; high holds the displayed value.
REQ-007 SHALL have port clear_n, input, 1: push button, asynchronous, active-low; a press clears the update counter.
REQ-008 SHALL have ports hex0..hex5, output, 7 each: active-low segments, bit0=a .. bit6=g.
REQ-009 SHALL have port change_pulse, output, 1: one-cycle strobe marking each accepted value change.

Function
REQ-010 SHALL register pio_value into last_q every cycle; change SHALL be defined as pio_value != last_q, evaluated combinationally.
REQ-011 On a change edge with freeze_s low, SHALL load disp_val with pio_value; with freeze_s high, disp_val SHALL hold.
REQ-012 SHALL increment the 16-bit update counter on every change edge regardless of freeze_s, saturating at 0xFFFF (no wrap).
REQ-013 SHALL register change_pulse high for exactly the one cycle after a change edge.
REQ-014 SHALL synchronise clear_n through SYNC_STAGES flops, then falling-edge detect; the detected edge SHALL clear the counter at the next clock edge.
REQ-015 Clear and change in the same cycle SHALL leave the counter at 1.
REQ-016 SHALL implement an FSM with states IDLE, FLASH_OFF, FLASH_ON, plus a 24-bit down-timer.
REQ-017 IDLE: on an accepted change (freeze_s low), SHALL go to FLASH_OFF and load the timer with FLASH_CYC-1.
REQ-018 FLASH_OFF: when the timer reaches 0, SHALL go to FLASH_ON and reload FLASH_CYC-1; FLASH_ON: when the timer reaches 0, SHALL go to IDLE.
REQ-019 An accepted change in FLASH_OFF or FLASH_ON SHALL restart FLASH_OFF with a fresh load; changes while frozen SHALL NOT affect the FSM.
REQ-020 hex1:hex0 SHALL show disp_val as hex digits, forced to blank (7'h7F) while in FLASH_OFF.
REQ-021 hex5:hex2 SHALL show the counter as four hex digits, MS digit on hex5, leading zeros displayed.
REQ-022 All hex outputs SHALL be registered, updating one cycle after disp_val, counter or state changes.
REQ-023 From a pio_value change sampled at edge N, change_pulse and hex5:hex0 (blanked) SHALL be valid after edge N+1; the counter SHALL reach hex5:hex2 after edge N+2.

Reset
REQ-024 Asserting reset_n low SHALL asynchronously force: last_q=0, disp_val=0, counter=0, timer=0, state=IDLE, change_pulse=0, synchronisers=released (freeze 0, clear_n 1), hex0..hex5=7'h40 ("0").
REQ-025 Reset mid-flash SHALL abort to IDLE with no residual blanking.
REQ-026 After release, a nonzero pio_value SHALL count as a change on the first edge.

Structure
REQ-027 Package pio_hex_pkg SHALL hold the state enum, SEG_BLANK=7'h7F and the 16-entry segment table.
REQ-028 Sub-module hex7seg (4-bit in, 7-bit active-low out, combinational) SHALL be instantiated six times.

Verification (FLASH_CYC=4)
REQ-029 Release reset, pio_value=0x00 held -> all hex=7'h40, change_pulse never asserted, counter 0.
REQ-030 pio_value 0x00->0xA5 -> one change_pulse; hex1:hex0 blank for 4 cycles, then 7'h08/7'h12 ("A5") for 4 cycles, then IDLE; hex2=7'h79 ("1").
REQ-031 Second change to 0x3C during FLASH_ON -> FLASH_OFF restarts with a full 4 cycles; counter=2.
REQ-032 freeze=1, then 0x3C->0x11 -> hex1:hex0 stay "3C", no blanking, counter increments to 3.
REQ-033 Counter preset to 0xFFFE, then three changes -> display "FFFF", no wrap; clear_n pulsed low together with a change -> counter=1.
REQ-034 reset_n asserted mid-FLASH_OFF -> outputs at REQ-024 values asynchronously, within the same cycle.
